// File: rtl/array_arith_pkg.sv
// Shared helpers for the pipelined array multiplier/divider family:
// operand widths, pipeline latency and placement of inter-row stage registers.
package array_arith_pkg;

  localparam int unsigned ARITH_DEFAULT_WIDTH  = 4;
  localparam int unsigned ARITH_DEFAULT_STAGES = 2;

  function automatic int unsigned prod_width(input int unsigned w);
    return 2 * w;
  endfunction

  function automatic int unsigned latency(input int unsigned s);
    return s + 1;
  endfunction

  // True when a boundary register follows the row that completes `row` rows
  // (row counted 1..w); boundaries sit at floor(k*w/(s+1)) for k = 1..s.
  function automatic logic stage_after_row(input int unsigned row,
                                           input int unsigned w,
                                           input int unsigned s);
    logic hit;
    hit = 1'b0;
    for (int unsigned k = 1; k <= s; k++) begin
      if ((k * w) / (s + 1) == row) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/array_divider_div_row.sv
// One combinational restoring-division row: shift in a dividend bit,
// trial-subtract the divisor, keep the difference or restore.
module div_row #(
  parameter int unsigned DATAWIDTH = 4
) (
  input  logic [DATAWIDTH:0]   P_in,
  input  logic                 Z_bit,
  input  logic [DATAWIDTH-1:0] B,
  output logic [DATAWIDTH:0]   P_out,
  output logic                 q_bit
);

  logic [DATAWIDTH+1:0] w_diff;

  // One extra bit on the trial difference acts as the borrow/sign.
  always_comb begin
    w_diff = {P_in, Z_bit} - {2'b00, B};
    q_bit  = ~w_diff[DATAWIDTH+1];
    P_out  = q_bit ? w_diff[DATAWIDTH:0] : {P_in[DATAWIDTH-1:0], Z_bit};
  end

endmodule

// File: rtl/array_divider.sv
// Pipelined restoring array divider: 2W-bit dividend / W-bit divisor, one
// row per quotient bit, optional boundary registers between rows.
module array_divider
  import array_arith_pkg::*;
#(
  parameter int unsigned DATAWIDTH           = ARITH_DEFAULT_WIDTH,
  parameter int unsigned NUM_PIPELINE_STAGES = ARITH_DEFAULT_STAGES,
  parameter int unsigned INSTANCE_ID         = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_valid,
  input  logic [prod_width(DATAWIDTH)-1:0] Z,
  input  logic [DATAWIDTH-1:0]             B,
  output logic                             o_valid,
  output logic [DATAWIDTH-1:0]             Q,
  output logic [DATAWIDTH-1:0]             R,
  output logic                             o_overflow
);

  localparam int unsigned W = DATAWIDTH;
  localparam int unsigned S = NUM_PIPELINE_STAGES;

  if (S >= W) begin : g_illegal
    $error("array_divider %0d: NUM_PIPELINE_STAGES=%0d must be below DATAWIDTH=%0d",
           INSTANCE_ID, S, W);
  end

  // Index j carries the state entering row j; index W is the array output.
  logic [W:0]   w_p   [W+1];
  logic [W-1:0] w_lo  [W+1];
  logic [W-1:0] w_b   [W+1];
  logic [W-1:0] w_q   [W+1];
  logic         w_ovf [W+1];
  logic         w_vld [W+1];

  assign w_p[0]   = {1'b0, Z[2*W-1:W]};
  assign w_lo[0]  = Z[W-1:0];
  assign w_b[0]   = B;
  assign w_q[0]   = '0;
  assign w_ovf[0] = (Z[2*W-1:W] >= B);
  assign w_vld[0] = i_valid;

  for (genvar j = 0; j < W; j++) begin : g_row
    logic [W:0]   w_prow;
    logic         w_qbit;
    logic [W-1:0] w_qacc;

    div_row #(.DATAWIDTH(W)) u_row (
      .P_in  (w_p[j]),
      .Z_bit (w_lo[j][W-1-j]),
      .B     (w_b[j]),
      .P_out (w_prow),
      .q_bit (w_qbit)
    );

    always_comb begin
      w_qacc        = w_q[j];
      w_qacc[W-1-j] = w_qbit;
    end

    if (stage_after_row(j + 1, W, S)) begin : g_stage
      logic [W:0]   r_p;
      logic [W-1:0] r_lo, r_b, r_q;
      logic         r_ovf, r_vld;

      // Data loads every cycle; only the valid bit is reset.
      always_ff @(posedge clk) begin
        r_p   <= w_prow;
        r_lo  <= w_lo[j];
        r_b   <= w_b[j];
        r_q   <= w_qacc;
        r_ovf <= w_ovf[j];
        if (rst) r_vld <= 1'b0;
        else     r_vld <= w_vld[j];
      end

      assign w_p[j+1]   = r_p;
      assign w_lo[j+1]  = r_lo;
      assign w_b[j+1]   = r_b;
      assign w_q[j+1]   = r_q;
      assign w_ovf[j+1] = r_ovf;
      assign w_vld[j+1] = r_vld;
    end else begin : g_wire
      assign w_p[j+1]   = w_prow;
      assign w_lo[j+1]  = w_lo[j];
      assign w_b[j+1]   = w_b[j];
      assign w_q[j+1]   = w_qacc;
      assign w_ovf[j+1] = w_ovf[j];
      assign w_vld[j+1] = w_vld[j];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid    <= 1'b0;
      Q          <= '0;
      R          <= '0;
      o_overflow <= 1'b0;
    end else begin
      o_valid <= w_vld[W];
      if (w_vld[W]) begin
        Q          <= w_ovf[W] ? '1 : w_q[W];
        R          <= w_ovf[W] ? '0 : w_p[W][W-1:0];
        o_overflow <= w_ovf[W];
      end
    end
  end

endmodule

// File: tb/tb_array_divider.sv
// Self-checking bench for array_divider: directed cases on W=4/S=2 plus
// random and multiply-loopback traffic on W=8 with S=0..3.
module tb_array_divider;
  import array_arith_pkg::*;

  localparam int unsigned NCFG = 5;

  typedef struct {
    logic [7:0]  q;
    logic [7:0]  r;
    logic        ovf;
    int unsigned due;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] z_in [NCFG];
  logic [7:0]  b_in [NCFG];
  logic        v_in [NCFG];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division with the high-half overflow rule.
  function automatic exp_t ref_div(input int unsigned w, input logic [15:0] z,
                                   input logic [7:0] b, input int unsigned due);
    exp_t        e;
    int unsigned zz, bb, hi;
    zz    = 32'(z) & ((32'd1 << (2 * w)) - 1);
    bb    = 32'(b) & ((32'd1 << w) - 1);
    hi    = zz >> w;
    e.due = due;
    if (hi >= bb) begin
      e.q   = 8'((32'd1 << w) - 1);
      e.r   = 8'd0;
      e.ovf = 1'b1;
    end else begin
      e.q   = 8'(zz / bb);
      e.r   = 8'(zz % bb);
      e.ovf = 1'b0;
    end
    return e;
  endfunction

  for (genvar c = 0; c < NCFG; c++) begin : g_cfg
    localparam int unsigned W   = (c == 0) ? 4 : 8;
    localparam int unsigned S   = (c == 0) ? 2 : c - 1;
    localparam int unsigned LAT = latency(S);

    logic         w_ov;
    logic [W-1:0] w_q;
    logic [W-1:0] w_r;
    logic         w_of;
    exp_t         sb[$];
    int unsigned  edges = 0;

    array_divider #(
      .DATAWIDTH           (W),
      .NUM_PIPELINE_STAGES (S),
      .INSTANCE_ID         (c)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .i_valid    (v_in[c]),
      .Z          (z_in[c][2*W-1:0]),
      .B          (b_in[c][W-1:0]),
      .o_valid    (w_ov),
      .Q          (w_q),
      .R          (w_r),
      .o_overflow (w_of)
    );

    always @(posedge clk) begin
      edges++;
      if (rst) sb.delete();
      else if (v_in[c]) sb.push_back(ref_div(W, z_in[c], b_in[c], edges + LAT - 1));
    end

    always @(negedge clk) begin
      if (sb.size() != 0 && sb[0].due == edges) begin
        check_eq($sformatf("c%0d.o_valid", c), 32'(w_ov), 32'd1);
        check_eq($sformatf("c%0d.Q", c), 32'(w_q), 32'(sb[0].q));
        check_eq($sformatf("c%0d.R", c), 32'(w_r), 32'(sb[0].r));
        check_eq($sformatf("c%0d.o_overflow", c), 32'(w_of), 32'(sb[0].ovf));
        void'(sb.pop_front());
      end else if (w_ov) begin
        check_eq($sformatf("c%0d.spurious_valid", c), 32'(w_ov), 32'd0);
      end
    end
  end

  task automatic check_idle0(input string tag);
    check_eq({tag, ".o_valid"}, 32'(g_cfg[0].w_ov), 32'd0);
    check_eq({tag, ".Q"}, 32'(g_cfg[0].w_q), 32'd0);
    check_eq({tag, ".R"}, 32'(g_cfg[0].w_r), 32'd0);
    check_eq({tag, ".o_overflow"}, 32'(g_cfg[0].w_of), 32'd0);
  endtask

  // Single op on the W=4/S=2 instance with explicit latency and hold checks.
  task automatic directed(input string tag, input logic [15:0] z, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er, input logic eo);
    @(negedge clk);
    z_in[0] = z; b_in[0] = b; v_in[0] = 1'b1;
    @(negedge clk);
    v_in[0] = 1'b0;
    @(negedge clk);
    check_eq({tag, ".early_valid"}, 32'(g_cfg[0].w_ov), 32'd0);
    @(negedge clk);
    check_eq({tag, ".o_valid"}, 32'(g_cfg[0].w_ov), 32'd1);
    check_eq({tag, ".Q"}, 32'(g_cfg[0].w_q), 32'(eq));
    check_eq({tag, ".R"}, 32'(g_cfg[0].w_r), 32'(er));
    check_eq({tag, ".o_overflow"}, 32'(g_cfg[0].w_of), 32'(eo));
    @(negedge clk);
    check_eq({tag, ".valid_drop"}, 32'(g_cfg[0].w_ov), 32'd0);
    check_eq({tag, ".Q_hold"}, 32'(g_cfg[0].w_q), 32'(eq));
  endtask

  initial begin
    int unsigned a, d;
    rst = 1'b1;
    for (int c = 0; c < NCFG; c++) begin
      v_in[c] = 1'b0; z_in[c] = '0; b_in[c] = '0;
    end
    repeat (3) @(negedge clk);
    check_idle0("reset");
    rst = 1'b0;

    directed("div35_5", 16'd35, 8'd5, 8'd7, 8'd0, 1'b0);
    directed("div224_15", 16'd224, 8'd15, 8'd14, 8'd14, 1'b0);
    directed("divby0", 16'hA7, 8'd0, 8'hF, 8'd0, 1'b1);
    directed("ovf50_5", 16'h50, 8'd5, 8'hF, 8'd0, 1'b1);

    // Back-to-back burst; the scoreboard checks order and consecutive timing.
    @(negedge clk); z_in[0] = 16'h3C; b_in[0] = 8'd7; v_in[0] = 1'b1;
    @(negedge clk); z_in[0] = 16'h1F; b_in[0] = 8'd3;
    @(negedge clk); z_in[0] = 16'h62; b_in[0] = 8'd9;
    @(negedge clk); z_in[0] = 16'h0B; b_in[0] = 8'd2;
    @(negedge clk); v_in[0] = 1'b0;
    repeat (4) @(negedge clk);

    // Two ops in flight, then a one-cycle reset.
    z_in[0] = 16'h2D; b_in[0] = 8'd6; v_in[0] = 1'b1;
    @(negedge clk); z_in[0] = 16'h41; b_in[0] = 8'd9;
    @(negedge clk); v_in[0] = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check_idle0("midrst");

    // Valid together with reset must be dropped.
    @(negedge clk); z_in[0] = 16'h35; b_in[0] = 8'd5; v_in[0] = 1'b1; rst = 1'b1;
    @(negedge clk); v_in[0] = 1'b0; rst = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check_eq($sformatf("post_rst_valid%0d", n), 32'(g_cfg[0].w_ov), 32'd0);
    end

    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      rst     = (n == 150);
      v_in[0] = ($urandom_range(0, 3) != 0);
      z_in[0] = 16'($urandom_range(0, 255));
      b_in[0] = 8'($urandom_range(0, 15));
      for (int c = 1; c < NCFG; c++) begin
        a       = $urandom_range(0, 255);
        d       = $urandom_range(1, 255);
        z_in[c] = 16'(a * d);
        b_in[c] = 8'(d);
        v_in[c] = ($urandom_range(0, 4) != 0);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < NCFG; c++) v_in[c] = 1'b0;
    repeat (8) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
